// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for the camera PLL: holds the PLL in reset, waits for a
// stable lock, then releases the downstream system reset. Re-sequences on lock loss,
// lock timeout or a restart request.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             piul1RefClock,
  input  logic             piul1Reset,
  input  logic             piul1PllLocked,
  input  logic             piul1Restart,
  output logic             poul1PllReset,
  output logic             poul1SysReset,
  output logic             poul1Ready,
  output logic [2:0]       poul3State,
  output logic [CNT_W-1:0] poulNRelockCount,
  output logic [CNT_W-1:0] poulNTimeoutCount
);

  localparam int unsigned MaxA   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                   : LOCK_TIMEOUT;
  localparam int unsigned MaxCyc = (MaxA > SETTLE_CYCLES) ? MaxA : SETTLE_CYCLES;
  localparam int unsigned CycW   = $clog2(MaxCyc + 1);

  localparam logic [CycW-1:0]  PllRstLast = CycW'(PLL_RST_CYCLES - 1);
  localparam logic [CycW-1:0]  LockLast   = CycW'(LOCK_TIMEOUT - 1);
  localparam logic [CycW-1:0]  SettleLast = CycW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EvtMax     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StSettle   = 3'd2,
    StRun      = 3'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic              cyc_clr;
  logic              lock_meta_q, lock_s_q;
  logic              relock_inc, timeout_inc;
  logic [CNT_W-1:0]  relock_q, timeout_q;
  logic              pll_reset_q, sys_reset_q, ready_q;

  always_comb begin
    state_d     = state_q;
    cyc_clr     = 1'b0;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    if (piul1Restart) begin
      state_d = StPllRst;
      cyc_clr = 1'b1;
    end else begin
      case (state_q)
        StPllRst: begin
          if (cyc_q == PllRstLast) begin
            state_d = StWaitLock;
            cyc_clr = 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StSettle;
            cyc_clr = 1'b1;
          end else if (cyc_q == LockLast) begin
            state_d     = StPllRst;
            cyc_clr     = 1'b1;
            timeout_inc = 1'b1;
          end
        end
        StSettle: begin
          // Any dropout restarts the settle window from WAIT_LOCK.
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cyc_clr = 1'b1;
          end else if (cyc_q == SettleLast) begin
            state_d = StRun;
            cyc_clr = 1'b1;
          end
        end
        StRun: begin
          cyc_clr = 1'b1;
          if (!lock_s_q) begin
            state_d    = StPllRst;
            relock_inc = 1'b1;
          end
        end
        default: begin
          state_d = StPllRst;
          cyc_clr = 1'b1;
        end
      endcase
    end
    cyc_d = cyc_clr ? '0 : cyc_q + CycW'(1);
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge piul1RefClock) begin
    if (piul1Reset) begin
      state_q     <= StPllRst;
      cyc_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      relock_q    <= '0;
      timeout_q   <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      lock_meta_q <= piul1PllLocked;
      lock_s_q    <= lock_meta_q;
      if (relock_inc && relock_q != EvtMax) relock_q <= relock_q + CNT_W'(1);
      if (timeout_inc && timeout_q != EvtMax) timeout_q <= timeout_q + CNT_W'(1);
      pll_reset_q <= (state_d == StPllRst);
      sys_reset_q <= (state_d != StRun);
      ready_q     <= (state_d == StRun);
    end
  end

  assign poul1PllReset     = pll_reset_q;
  assign poul1SysReset     = sys_reset_q;
  assign poul1Ready        = ready_q;
  assign poul3State        = state_q;
  assign poulNRelockCount  = relock_q;
  assign poulNTimeoutCount = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: per-cycle vector table plus hand sequences for
// timeout, lock loss, settle glitch, counter saturation and restart/reset priority.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic [2:0] state;
  logic [1:0] relock_cnt;
  logic [1:0] timeout_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(16),
    .LOCK_TIMEOUT  (64),
    .SETTLE_CYCLES (256),
    .CNT_W         (2)
  ) dut (
    .piul1RefClock    (clk),
    .piul1Reset       (rst),
    .piul1PllLocked   (lock),
    .piul1Restart     (restart),
    .poul1PllReset    (pll_reset),
    .poul1SysReset    (sys_reset),
    .poul1Ready       (ready),
    .poul3State       (state),
    .poulNRelockCount (relock_cnt),
    .poulNTimeoutCount(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       restart;
    logic       lock;
    int         n;
    logic [2:0] st;
    logic       pll;
    logic       sys;
    logic       rdy;
  } vec_t;

  vec_t vecs[11];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      step(1);
      if (ready) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int pll_hi;
    int ready_at;
    int cyc;

    // Test 1: reset values and lock-held startup latency.
    rst = 1'b1; restart = 1'b0; lock = 1'b1;
    step(1);
    check("rst_state", state, 0);
    check("rst_pll", pll_reset, 1);
    check("rst_sys", sys_reset, 1);
    check("rst_ready", ready, 0);
    check("rst_cnts", {relock_cnt, timeout_cnt}, 0);
    rst = 1'b0;
    pll_hi = 1;
    ready_at = -1;
    for (int k = 1; k <= 400; k++) begin
      step(1);
      if (pll_reset) pll_hi++;
      if (ready) begin
        ready_at = k;
        break;
      end
    end
    check("t1_ready_latency", ready_at, 273);
    check("t1_pll_high_cycles", pll_hi, 16);
    check("t1_sys_released", sys_reset, 0);
    check("t1_cnts", {relock_cnt, timeout_cnt}, 0);

    // Test 3: one-cycle lock drop in RUN.
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    check("t3_ready_d1", ready, 1);
    step(1);
    check("t3_ready_d2", ready, 1);
    step(1);
    check("t3_ready_d3", ready, 0);
    check("t3_sys_d3", sys_reset, 1);
    check("t3_state_d3", state, 0);
    check("t3_relock", relock_cnt, 1);
    wait_ready(400, cyc);
    check("t3_rerun_latency", cyc, 273);

    // Test 6: restart coincides with synchronized lock loss; then reset in WAIT_LOCK.
    lock = 1'b0;
    step(2);
    restart = 1'b1;
    lock = 1'b1;
    step(1);
    restart = 1'b0;
    check("t6_state", state, 0);
    check("t6_relock_kept", relock_cnt, 1);
    step(16);
    check("t6_wait_lock", state, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_rst_outs", {state, pll_reset, sys_reset, ready}, {3'd0, 3'b110});
    check("t6_rst_cnts", {relock_cnt, timeout_cnt}, 0);

    // Test 4: lock glitch while SETTLE count is 100 (sequence started at the reset edge).
    step(115);
    check("t4_in_settle", state, 2);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(1);
    check("t4_settle_cnt100", state, 2);
    step(1);
    check("t4_back_wait", state, 1);
    wait_ready(400, cyc);
    check("t4_fresh_settle", cyc, 257);
    check("t4_cnts", {relock_cnt, timeout_cnt}, 0);

    // Test 2: lock never arrives; retry every 16+64 cycles, timeout counter saturates.
    rst = 1'b1; lock = 1'b0;
    step(1);
    rst = 1'b0;
    step(79);
    check("t2_wait_last", {state, pll_reset}, {3'd1, 1'b0});
    step(1);
    check("t2_retry1", {state, pll_reset}, {3'd0, 1'b1});
    check("t2_tmo1", timeout_cnt, 1);
    step(80);
    check("t2_tmo2", {pll_reset, timeout_cnt}, {1'b1, 2'd2});
    step(80);
    check("t2_tmo3", timeout_cnt, 3);
    step(80);
    check("t2_tmo_sat", {state, timeout_cnt}, {3'd0, 2'd3});
    check("t2_relock", relock_cnt, 0);

    // Test 5: five lock losses from RUN, relock counter saturates at 3.
    rst = 1'b1; lock = 1'b1;
    step(1);
    rst = 1'b0;
    wait_ready(400, cyc);
    check("t5_first_run", cyc, 273);
    for (int i = 0; i < 5; i++) begin
      lock = 1'b0;
      step(1);
      lock = 1'b1;
      step(2);
      check($sformatf("t5_relock_%0d", i), relock_cnt, (i < 2) ? i + 1 : 3);
      check($sformatf("t5_dropped_%0d", i), ready, 0);
      wait_ready(400, cyc);
      check($sformatf("t5_rerun_%0d", i), cyc, 273);
    end
    check("t5_tmo", timeout_cnt, 0);

    // Per-cycle vectors: restart clears the PLL_RST counter, restart from RUN, reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1,   3'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 10,  3'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1,   3'd0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 15,  3'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1,   3'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1,   3'd2, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 255, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1,   3'd3, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1,   3'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16,  3'd1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1,   3'd0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rst     = vecs[i].rst;
      restart = vecs[i].restart;
      lock    = vecs[i].lock;
      step(vecs[i].n);
      check($sformatf("vec%0d_{st,pll,sys,rdy}", i), {state, pll_reset, sys_reset, ready},
            {vecs[i].st, vecs[i].pll, vecs[i].sys, vecs[i].rdy});
    end
    rst = 1'b0;
    restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
